// File: rtl/vec_stream_cache_pkg.sv
// vec_stream_cache shared types: read/write op codes, stream FSM states.
// Lane-range helper used by the cache write and read muxes.
package vec_pkg;

  typedef enum logic [1:0] {
    VEC_DATA_READ_DISABLE,
    VEC_DATA_READ_VEC,
    VEC_DATA_READ_SCALAR
  } VecDataReadOp_t;

  typedef enum logic [2:0] {
    VEC_DATA_WRITE_DISABLE,
    VEC_DATA_WRITE_VEC,
    VEC_DATA_WRITE_SCALAR,
    VEC_DATA_WRITE_BROADCAST,
    VEC_DATA_WRITE_STREAM
  } VecDataWriteOp_t;

  typedef enum logic [1:0] {
    STREAM_IDLE,
    STREAM_FILL,
    STREAM_DONE
  } stream_state_t;

  function automatic logic lane_ok(
    input int unsigned lane,
    input int unsigned width
  );
    return lane < width;
  endfunction

endpackage

// File: rtl/vec_stream_cache_if.sv
// Bus between the vector datapath (master) and vec_stream_cache (slave).
// Carries read/write ops, stream fill handshake and registered read data.
interface vec_stream_cache_if
  import vec_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(WIDTH);

  VecDataReadOp_t                   read_op;
  logic [AW-1:0]                    read_addr;
  logic [LW-1:0]                    read_param;
  VecDataWriteOp_t                  write_op;
  logic [AW-1:0]                    write_addr;
  logic [LW-1:0]                    write_param;
  logic [WIDTH-1:0][DATA_W-1:0]     data_in;
  logic [DATA_W-1:0]                stream_in;
  logic                             stream_valid;
  logic                             stream_ready;
  logic                             stream_done;
  logic                             busy;
  logic [WIDTH-1:0][DATA_W-1:0]     data_out;
  logic                             read_valid;

  modport master (
    output read_op, read_addr, read_param,
    output write_op, write_addr, write_param,
    output data_in, stream_in, stream_valid,
    input  stream_ready, stream_done, busy,
    input  data_out, read_valid
  );

  modport slave (
    input  read_op, read_addr, read_param,
    input  write_op, write_addr, write_param,
    input  data_in, stream_in, stream_valid,
    output stream_ready, stream_done, busy,
    output data_out, read_valid
  );

endinterface

// File: rtl/vec_stream_cache_ctrl.sv
// vec_stream_ctrl: stream fill FSM and lane counter.
// Status outputs decode straight from the registered state.
module vec_stream_ctrl
  import vec_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start_i,
  input  logic [$clog2(DEPTH)-1:0] start_row_i,
  input  logic                     stream_valid_i,
  output logic                     busy_o,
  output logic                     stream_ready_o,
  output logic                     stream_done_o,
  output logic                     beat_we_o,
  output logic [$clog2(WIDTH)-1:0] beat_lane_o,
  output logic [$clog2(DEPTH)-1:0] row_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(WIDTH);
  localparam logic [LW-1:0] LAST = LW'(WIDTH - 1);

  stream_state_t state_q;
  logic [LW-1:0] cnt_q;
  logic [AW-1:0] row_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= STREAM_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
    end else begin
      unique case (state_q)
        STREAM_IDLE: begin
          if (start_i) begin
            row_q   <= start_row_i;
            cnt_q   <= '0;
            state_q <= STREAM_FILL;
          end
        end
        STREAM_FILL: begin
          if (stream_valid_i) begin
            cnt_q <= cnt_q + LW'(1);
            if (cnt_q == LAST) state_q <= STREAM_DONE;
          end
        end
        STREAM_DONE: state_q <= STREAM_IDLE;
        default:     state_q <= STREAM_IDLE;
      endcase
    end
  end

  assign busy_o         = (state_q == STREAM_FILL);
  assign stream_ready_o = (state_q == STREAM_FILL);
  assign stream_done_o  = (state_q == STREAM_DONE);
  assign beat_we_o      = (state_q == STREAM_FILL) && stream_valid_i;
  assign beat_lane_o    = cnt_q;
  assign row_o          = row_q;

endmodule

// File: rtl/vec_stream_cache.sv
// vec_stream_cache: DEPTH x WIDTH lane vector cache with stream fill.
// VEC_CACHE_ZERO_INIT_EN: reset also clears storage (else memory-inferable).
module vec_stream_cache
  import vec_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  vec_stream_cache_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(WIDTH);

  typedef logic [WIDTH-1:0][DATA_W-1:0] row_t;

  row_t          mem_q [DEPTH];
  row_t          data_out_q, data_out_d;
  logic          read_valid_q, read_valid_d;

  logic          busy, done, idle;
  logic          beat_we;
  logic [LW-1:0] beat_lane;
  logic [AW-1:0] s_row;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  row_t          wr_row;
  row_t          rd_row;

  vec_stream_ctrl #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clock          (clock),
    .reset_n        (reset_n),
    .start_i        (bus.write_op == VEC_DATA_WRITE_STREAM),
    .start_row_i    (bus.write_addr),
    .stream_valid_i (bus.stream_valid),
    .busy_o         (busy),
    .stream_ready_o (bus.stream_ready),
    .stream_done_o  (done),
    .beat_we_o      (beat_we),
    .beat_lane_o    (beat_lane),
    .row_o          (s_row)
  );

  assign idle = !busy && !done;

  // wr_row is the full post-write row; reused for forwarding.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = bus.write_addr;
    wr_row  = mem_q[bus.write_addr];
    if (beat_we) begin
      wr_en   = 1'b1;
      wr_addr = s_row;
      wr_row  = mem_q[s_row];
      wr_row[beat_lane] = bus.stream_in;
    end else if (idle) begin
      unique case (bus.write_op)
        VEC_DATA_WRITE_VEC: begin
          wr_en  = 1'b1;
          wr_row = bus.data_in;
        end
        VEC_DATA_WRITE_SCALAR: begin
          if (lane_ok(32'(bus.write_param), WIDTH)) begin
            wr_en = 1'b1;
            wr_row[bus.write_param] = bus.data_in[0];
          end
        end
        VEC_DATA_WRITE_BROADCAST: begin
          wr_en = 1'b1;
          for (int l = 0; l < WIDTH; l++) wr_row[l] = bus.data_in[0];
        end
        default: ;
      endcase
    end
  end

`ifdef VEC_CACHE_ZERO_INIT_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_row;
    end
  end
`else
  always_ff @(posedge clock) begin
    if (reset_n && wr_en) mem_q[wr_addr] <= wr_row;
  end
`endif

  assign rd_row = (wr_en && (wr_addr == bus.read_addr))
                ? wr_row : mem_q[bus.read_addr];

  always_comb begin
    data_out_d   = data_out_q;
    read_valid_d = (bus.read_op != VEC_DATA_READ_DISABLE);
    unique case (bus.read_op)
      VEC_DATA_READ_VEC: data_out_d = rd_row;
      VEC_DATA_READ_SCALAR: begin
        data_out_d = '0;
        if (lane_ok(32'(bus.read_param), WIDTH))
          data_out_d[0] = rd_row[bus.read_param];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      data_out_q   <= '0;
      read_valid_q <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      read_valid_q <= read_valid_d;
    end
  end

  assign bus.busy        = busy;
  assign bus.stream_done = done;
  assign bus.data_out    = data_out_q;
  assign bus.read_valid  = read_valid_q;

endmodule

// File: tb/tb_vec_stream_cache.sv
// Scoreboard bench for vec_stream_cache: reads push expectations,
// a negedge monitor pops on read_valid; status checked inline.
module tb_vec_stream_cache;
  import vec_pkg::*;

  localparam int WIDTH  = 4;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int RW     = WIDTH * DATA_W;

  typedef logic [WIDTH-1:0][DATA_W-1:0] row_t;

  localparam logic [31:0] F2 = 32'h4000_0000;
  localparam logic [31:0] F4 = 32'h4080_0000;

  logic clock;
  logic reset_n;

  vec_stream_cache_if #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) bus ();

  vec_stream_cache #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   n_tests = 0;
  int   n_fail  = 0;
  row_t exp_q[$];

  function automatic row_t mk(
    input logic [31:0] a, b, c, d
  );
    row_t r;
    r[0] = a;
    r[1] = b;
    r[2] = c;
    r[3] = d;
    return r;
  endfunction

  task automatic chk(
    input string        nm,
    input logic [RW-1:0] got,
    input logic [RW-1:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    bus.read_op      = VEC_DATA_READ_DISABLE;
    bus.write_op     = VEC_DATA_WRITE_DISABLE;
    bus.stream_valid = 1'b0;
  endtask

  task automatic rd_vec(input int row, input row_t exp);
    bus.read_op   = VEC_DATA_READ_VEC;
    bus.read_addr = 2'(row);
    exp_q.push_back(exp);
  endtask

  task automatic wr_vec(input int row, input row_t d);
    bus.write_op   = VEC_DATA_WRITE_VEC;
    bus.write_addr = 2'(row);
    bus.data_in    = d;
  endtask

  task automatic status(
    input string nm,
    input logic b, r, dn
  );
    @(negedge clock);
    chk({nm, "_busy"},  RW'(bus.busy), RW'(b));
    chk({nm, "_ready"}, RW'(bus.stream_ready), RW'(r));
    chk({nm, "_done"},  RW'(bus.stream_done), RW'(dn));
  endtask

  // Monitor: every valid read result must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clock);
      if (bus.read_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_read", bus.data_out, '0);
          n_fail += (bus.data_out === '0) ? 1 : 0;
        end else begin
          chk("read_data", bus.data_out, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset_n         = 1'b0;
    bus.read_addr   = '0;
    bus.read_param  = '0;
    bus.write_addr  = '0;
    bus.write_param = '0;
    bus.data_in     = '0;
    bus.stream_in   = '0;
    idle_in();
    tick();
    tick();
    @(negedge clock);
    chk("rst_data_out", bus.data_out, '0);
    chk("rst_read_valid", RW'(bus.read_valid), '0);
    status("rst", 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    tick();

    wr_vec(1, mk(9, 7, 5, 3));
    tick();
    idle_in();
    rd_vec(1, mk(9, 7, 5, 3));
    tick();
    idle_in();
    tick();
    @(negedge clock);
    chk("hold_data", bus.data_out, mk(9, 7, 5, 3));
    chk("hold_valid", RW'(bus.read_valid), '0);

    bus.write_op    = VEC_DATA_WRITE_SCALAR;
    bus.write_addr  = 2'd1;
    bus.write_param = 2'd2;
    bus.data_in     = mk(F2, 32'hdead, 32'hbeef, 32'hcafe);
    tick();
    idle_in();
    rd_vec(1, mk(9, 7, F2, 3));
    tick();
    bus.read_op    = VEC_DATA_READ_SCALAR;
    bus.read_addr  = 2'd1;
    bus.read_param = 2'd3;
    exp_q.push_back(mk(3, 0, 0, 0));
    tick();
    idle_in();
    bus.write_op   = VEC_DATA_WRITE_BROADCAST;
    bus.write_addr = 2'd0;
    bus.data_in    = mk(F4, 11, 12, 13);
    tick();
    idle_in();
    rd_vec(0, mk(F4, F4, F4, F4));
    tick();

    wr_vec(2, mk(1, 2, 3, 4));
    rd_vec(2, mk(1, 2, 3, 4));
    tick();
    idle_in();
    wr_vec(3, mk(32'ha0, 32'ha1, 32'ha2, 32'ha3));
    tick();

    idle_in();
    bus.write_op   = VEC_DATA_WRITE_STREAM;
    bus.write_addr = 2'd3;
    tick();
    idle_in();
    status("fill0", 1'b1, 1'b1, 1'b0);
    wr_vec(3, mk(99, 99, 99, 99));
    bus.stream_valid = 1'b1;
    bus.stream_in    = 32'd5;
    rd_vec(3, mk(5, 32'ha1, 32'ha2, 32'ha3));
    tick();
    bus.stream_in = 32'd6;
    rd_vec(3, mk(5, 6, 32'ha2, 32'ha3));
    tick();
    bus.read_op      = VEC_DATA_READ_DISABLE;
    bus.stream_valid = 1'b0;
    tick();
    status("gap", 1'b1, 1'b1, 1'b0);
    bus.stream_valid = 1'b1;
    bus.stream_in    = 32'd7;
    tick();
    bus.stream_in = 32'd8;
    tick();
    status("done", 1'b0, 1'b0, 1'b1);
    idle_in();
    wr_vec(3, mk(77, 77, 77, 77));
    tick();
    status("after_done", 1'b0, 1'b0, 1'b0);
    idle_in();
    rd_vec(3, mk(5, 6, 7, 8));
    tick();

    idle_in();
    bus.write_op   = VEC_DATA_WRITE_STREAM;
    bus.write_addr = 2'd3;
    tick();
    idle_in();
    bus.stream_valid = 1'b1;
    bus.stream_in    = 32'h51;
    tick();
    bus.stream_in = 32'h52;
    rd_vec(3, mk(32'h51, 32'h52, 7, 8));
    tick();
    idle_in();
    reset_n = 1'b0;
    tick();
    @(negedge clock);
    chk("mid_rst_data_out", bus.data_out, '0);
    chk("mid_rst_valid", RW'(bus.read_valid), '0);
    status("mid_rst", 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    tick();
`ifdef VEC_CACHE_ZERO_INIT_EN
    for (int r = 0; r < DEPTH; r++) begin
      rd_vec(r, '0);
      tick();
    end
`else
    rd_vec(3, mk(32'h51, 32'h52, 7, 8));
    tick();
`endif
    idle_in();
    tick();
    status("post_rst", 1'b0, 1'b0, 1'b0);
    tick();
    @(negedge clock);
    chk("queue_drained", RW'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
